// File: rtl/power2round_recombine.sv
// -----------------------------------------------------------------------------
// power2round_recombine
//
// Streaming inverse of the ML-DSA Power2Round split. Each accepted (r1, r0)
// pair is rebuilt as r = r1*2^D + r0s, where r0s is the centered residue
// carried in r0, and then folded into [0, MLDSA_Q). Results that needed
// folding are flagged through the sticky range_err. A per-polynomial
// coefficient counter tags every output with its position.
//
// Ports:
//   clk        clock
//   rst_b      asynchronous active-low reset
//   zeroize    synchronous clear of all state, highest priority
//   in_valid   input pair valid
//   in_ready   block can accept the pair (combinational)
//   in_r1      high part, unsigned, REG_SIZE-MLDSA_D bits
//   in_r0      low part, centered encoding, MLDSA_D bits
//   out_valid  result valid
//   out_ready  downstream accepts
//   out_r      reconstructed coefficient mod MLDSA_Q
//   out_idx    position of out_r within its polynomial
//   out_last   out_idx == MLDSA_N-1
//   range_err  sticky: some handshaked coefficient was out of range
//   poly_done  one-cycle pulse after the last coefficient's handshake
// -----------------------------------------------------------------------------
module power2round_recombine #(
  parameter int                  REG_SIZE = 23,
  parameter logic [REG_SIZE-1:0] MLDSA_Q  = 23'd8380417,
  parameter int                  MLDSA_D  = 13,
  parameter int                  MLDSA_N  = 256
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         zeroize,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_SIZE-MLDSA_D-1:0]  in_r1,
  input  logic [MLDSA_D-1:0]           in_r0,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [REG_SIZE-1:0]          out_r,
  output logic [$clog2(MLDSA_N)-1:0]   out_idx,
  output logic                         out_last,
  output logic                         range_err,
  output logic                         poly_done
);

  localparam int R1_W  = REG_SIZE - MLDSA_D;
  localparam int V_W   = REG_SIZE + 1;
  localparam int IDX_W = $clog2(MLDSA_N);

  // Fold a signed reconstruction into [0, Q). Bit REG_SIZE of the result is
  // the out-of-range flag. The input never reaches 2Q, so one correction
  // step in either direction is enough.
  function automatic logic [REG_SIZE:0] reduce_mod_q(input logic signed [V_W-1:0] v);
    logic signed [V_W-1:0] q_ext;
    logic signed [V_W-1:0] fixed;
    q_ext = $signed({1'b0, MLDSA_Q});
    fixed = v;
    if (v < 0) begin
      fixed = v + q_ext;
      return {1'b1, fixed[REG_SIZE-1:0]};
    end else if (v >= q_ext) begin
      fixed = v - q_ext;
      return {1'b1, fixed[REG_SIZE-1:0]};
    end
    return {1'b0, fixed[REG_SIZE-1:0]};
  endfunction

  logic                        borrow_p0;
  logic signed [R1_W:0]        r1_adj_p0;
  logic signed [V_W-1:0]       v_p0;
  logic signed [V_W-1:0]       v_p1;
  logic                        vld_p1;
  logic [REG_SIZE:0]           red_p1;
  logic [REG_SIZE-1:0]         r_p2;
  logic                        err_p2;
  logic                        vld_p2;
  logic [IDX_W-1:0]            idx_q;
  logic                        s1_adv;
  logic                        s2_adv;
  logic                        out_hs;

  // ---- Stage 0 -> 1: centered decode. A negative r0 borrows one from r1;
  // the low D bits are then reused unchanged, which equals r1*2^D + r0s.
  assign borrow_p0 = in_r0[MLDSA_D-1] & (|in_r0[MLDSA_D-2:0]);
  assign r1_adj_p0 = $signed({1'b0, in_r1}) - $signed({{R1_W{1'b0}}, borrow_p0});
  assign v_p0      = {r1_adj_p0, in_r0};

  // ---- Stage 1 -> 2: modular correction.
  assign red_p1 = reduce_mod_q(v_p1);

  assign s2_adv    = !vld_p2 | out_ready;
  assign s1_adv    = !vld_p1 | s2_adv;
  assign in_ready  = s1_adv;
  assign out_hs    = vld_p2 & out_ready;

  assign out_valid = vld_p2;
  assign out_r     = r_p2;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == IDX_W'(MLDSA_N - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p1    <= 1'b0;
      v_p1      <= '0;
      vld_p2    <= 1'b0;
      r_p2      <= '0;
      err_p2    <= 1'b0;
      idx_q     <= '0;
      range_err <= 1'b0;
      poly_done <= 1'b0;
    end else if (zeroize) begin
      vld_p1    <= 1'b0;
      v_p1      <= '0;
      vld_p2    <= 1'b0;
      r_p2      <= '0;
      err_p2    <= 1'b0;
      idx_q     <= '0;
      range_err <= 1'b0;
      poly_done <= 1'b0;
    end else begin
      if (s1_adv) begin
        vld_p1 <= in_valid & in_ready;
        v_p1   <= v_p0;
      end
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        r_p2   <= red_p1[REG_SIZE-1:0];
        err_p2 <= red_p1[REG_SIZE];
      end
      // Counter wraps naturally because MLDSA_N is a power of two.
      if (out_hs) idx_q <= idx_q + 1'b1;
      if (out_hs & err_p2) range_err <= 1'b1;
      poly_done <= out_hs & out_last;
    end
  end

endmodule

// File: tb/tb_power2round_recombine.sv
// -----------------------------------------------------------------------------
// tb_power2round_recombine
//
// Directed bench for power2round_recombine: streaming legal values, overflow,
// underflow, a full polynomial with random output stalls, backpressure depth,
// and zeroize / asynchronous reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_power2round_recombine;

  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        zeroize = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_r1 = '0;
  logic [12:0] in_r0 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_r;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        range_err;
  logic        poly_done;

  power2round_recombine dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .zeroize   (zeroize),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r1     (in_r1),
    .in_r0     (in_r0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .range_err (range_err),
    .poly_done (poly_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output / input handshake monitor, sampled on the falling edge.
  int got_r[$];
  int got_idx[$];
  int got_last[$];
  int got_cyc[$];
  int acc_cyc[$];
  int pd_count = 0;
  int pd_cyc   = 0;
  logic        stall_prev = 1'b0;
  logic [22:0] held_r;
  logic [7:0]  held_idx;
  logic        held_last;

  always @(negedge clk) begin
    if (rst_b && !zeroize) begin
      if (out_valid && out_ready) begin
        got_r.push_back(int'(out_r));
        got_idx.push_back(int'(out_idx));
        got_last.push_back(int'(out_last));
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (poly_done) begin
        pd_count++;
        pd_cyc = cyc;
      end
      if (stall_prev && out_valid) begin
        check("stall_r", 32'(out_r), 32'(held_r));
        check("stall_idx", 32'(out_idx), 32'(held_idx));
        check("stall_last", 32'(out_last), 32'(held_last));
      end
      stall_prev = out_valid && !out_ready;
      held_r     = out_r;
      held_idx   = out_idx;
      held_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  int vec_r1[256];
  int vec_r0[256];
  int vec_exp[256];

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Forward Power2Round: r1 = round(r / 2^13), r0 = r - r1*2^13 as 13-bit code.
  function automatic void p2r(input int r, output int r1, output int r0enc);
    r1    = (r + 4095) >>> 13;
    r0enc = (r - r1 * 8192) & 8191;
  endfunction

  task automatic clear_mon();
    got_r.delete();
    got_idx.delete();
    got_last.delete();
    got_cyc.delete();
    acc_cyc.delete();
    pd_count = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_zeroize();
    @(posedge clk);
    #1;
    zeroize   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
  endtask

  // Present vec[start..n-1] one pair at a time; rnd selects random out_ready.
  task automatic feed(input int start, input int n, input bit rnd);
    int sent;
    int guard;
    bit acc;
    sent  = start;
    guard = 0;
    acc   = 1'b0;
    while (sent < n && guard < 4000) begin
      @(posedge clk);
      #1;
      if (acc) sent++;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = (sent < n);
      in_r1     = 10'(vec_r1[sent % 256]);
      in_r0     = 13'(vec_r0[sent % 256]);
      @(negedge clk);
      acc = in_valid && in_ready;
      guard++;
    end
    check("feed_done", 32'(sent), 32'(n));
  endtask

  task automatic drain(input int n, input bit rnd);
    int guard;
    guard = 0;
    while (got_r.size() < n && guard < 2000) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  // Hold out_ready low while offering vec[start..]; returns pairs accepted.
  task automatic stall_fill(input int start, input int cycles, output int accepted);
    int sent;
    bit acc;
    sent      = start;
    acc       = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (acc) sent++;
      in_valid = 1'b1;
      in_r1    = 10'(vec_r1[sent]);
      in_r0    = 13'(vec_r0[sent]);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    accepted = sent - start + int'(acc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r0e, r, n_acc;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_r", 32'(out_r), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_range_err", 32'(range_err), 0);
    check("rst_poly_done", 32'(poly_done), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick(2);

    // Legal values, streaming
    clear_mon();
    vec_r1[0] = 1023; vec_r0[0] = 'h0000; vec_exp[0] = 8380416;
    vec_r1[1] = 5;    vec_r0[1] = 'h1000; vec_exp[1] = 45056;
    vec_r1[2] = 5;    vec_r0[2] = 'h1001; vec_exp[2] = 36865;
    vec_r1[3] = 0;    vec_r0[3] = 'h0FFF; vec_exp[3] = 4095;
    feed(0, 4, 1'b0);
    drain(4, 1'b0);
    check("stream_count", 32'(got_r.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("stream_r", 32'(at(got_r, i)), 32'(vec_exp[i]));
      check("stream_lat", 32'(at(got_cyc, i) - at(acc_cyc, 0)), 32'(2 + i));
    end
    check("stream_range_err", 32'(range_err), 0);

    // Overflow: v == Q
    clear_mon();
    vec_r1[0] = 1023; vec_r0[0] = 'h0001;
    feed(0, 1, 1'b0);
    drain(1, 1'b0);
    check("ovf_r", 32'(at(got_r, 0)), 0);
    check("ovf_idx", 32'(at(got_idx, 0)), 4);
    check("ovf_range_err", 32'(range_err), 1);
    tick(3);
    check("ovf_sticky", 32'(range_err), 1);

    // Underflow: v == -1
    do_zeroize();
    @(negedge clk);
    check("zero_range_err", 32'(range_err), 0);
    check("zero_idx", 32'(out_idx), 0);
    clear_mon();
    vec_r1[0] = 0; vec_r0[0] = 'h1FFF;
    feed(0, 1, 1'b0);
    drain(1, 1'b0);
    check("unf_r", 32'(at(got_r, 0)), 8380416);
    check("unf_range_err", 32'(range_err), 1);

    // Full polynomial with random stalls
    do_zeroize();
    clear_mon();
    for (int i = 0; i < 256; i++) begin
      r = (i == 0) ? Q - 1 : (i == 1) ? 0 : int'($urandom_range(0, Q - 1));
      p2r(r, r1, r0e);
      vec_r1[i] = r1; vec_r0[i] = r0e; vec_exp[i] = r;
    end
    feed(0, 256, 1'b1);
    drain(256, 1'b1);
    tick(3);
    check("poly_count", 32'(got_r.size()), 256);
    for (int i = 0; i < 256; i++) begin
      check("poly_r", 32'(at(got_r, i)), 32'(vec_exp[i]));
      check("poly_idx", 32'(at(got_idx, i)), 32'(i));
      check("poly_last", 32'(at(got_last, i)), (i == 255) ? 1 : 0);
    end
    check("poly_done_count", 32'(pd_count), 1);
    check("poly_done_cyc", 32'(pd_cyc), 32'(at(got_cyc, 255) + 1));
    check("poly_range_err", 32'(range_err), 0);

    // Backpressure depth
    clear_mon();
    for (int k = 0; k < 5; k++) begin
      vec_r1[k] = k + 1; vec_r0[k] = 3 * k; vec_exp[k] = (k + 1) * 8192 + 3 * k;
    end
    stall_fill(0, 6, n_acc);
    check("bp_accepted", 32'(n_acc), 2);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    feed(2, 5, 1'b0);
    drain(5, 1'b0);
    check("bp_count", 32'(got_r.size()), 5);
    for (int k = 0; k < 5; k++) check("bp_r", 32'(at(got_r, k)), 32'(vec_exp[k]));
    check("bp_idx0", 32'(at(got_idx, 0)), 0);

    // Zeroize at idx 100 with both stages full
    do_zeroize();
    clear_mon();
    vec_r1[0] = 1023; vec_r0[0] = 1;
    for (int i = 1; i < 102; i++) begin
      vec_r1[i] = i; vec_r0[i] = 0;
    end
    feed(0, 100, 1'b0);
    drain(100, 1'b0);
    @(negedge clk);
    check("zpre_idx", 32'(out_idx), 100);
    check("zpre_range_err", 32'(range_err), 1);
    stall_fill(100, 4, n_acc);
    check("zpre_full", 32'(n_acc), 2);
    check("zpre_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    zeroize = 1'b1;
    out_ready = 1'b1;
    vec_r1[0] = 9; vec_r0[0] = 9;
    in_r1 = 10'd9; in_r0 = 13'd9;
    @(posedge clk);
    #1;
    zeroize  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("z_out_valid", 32'(out_valid), 0);
    check("z_out_idx", 32'(out_idx), 0);
    check("z_range_err", 32'(range_err), 0);
    check("z_poly_done", 32'(poly_done), 0);
    check("z_out_r", 32'(out_r), 0);
    clear_mon();
    tick(3);
    check("z_no_capture", 32'(got_r.size()), 0);
    vec_r1[0] = 7; vec_r0[0] = 5;
    feed(0, 1, 1'b0);
    drain(1, 1'b0);
    check("z_next_idx", 32'(at(got_idx, 0)), 0);
    check("z_next_r", 32'(at(got_r, 0)), 57349);

    // Asynchronous reset mid-stream
    clear_mon();
    vec_r1[0] = 1023; vec_r0[0] = 1;
    for (int i = 1; i < 12; i++) begin
      vec_r1[i] = i; vec_r0[i] = 0;
    end
    feed(0, 10, 1'b0);
    drain(10, 1'b0);
    @(negedge clk);
    check("rpre_idx", 32'(out_idx), 11);
    check("rpre_range_err", 32'(range_err), 1);
    stall_fill(10, 4, n_acc);
    check("rpre_full", 32'(n_acc), 2);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("r_out_valid", 32'(out_valid), 0);
    check("r_out_idx", 32'(out_idx), 0);
    check("r_range_err", 32'(range_err), 0);
    check("r_in_ready", 32'(in_ready), 1);
    check("r_out_r", 32'(out_r), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_b    = 1'b1;
    tick(1);
    clear_mon();
    vec_r1[0] = 3; vec_r0[0] = 'h1FFF;
    feed(0, 1, 1'b0);
    drain(1, 1'b0);
    check("r_next_idx", 32'(at(got_idx, 0)), 0);
    check("r_next_r", 32'(at(got_r, 0)), 24575);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
